exe_stage: RTL and testbench



---
 rtl/exe_stage_if.sv | 44 ++++
 rtl/exe_stage.sv | 116 +++++++++++
 tb/tb_exe_stage.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/exe_stage_if.sv
// Execute-stage bus: ID/EXE register outputs going in, EXE/MEM register and
// branch/status outputs coming out.
interface exe_stage_if #(parameter int WIDTH = 32);
  logic             wb_en_in;
  logic             mem_read_in;
  logic             mem_write_in;
  logic             b_in;
  logic             s_in;
  logic [3:0]       exe_cmd_in;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] val_rn_in;
  logic [WIDTH-1:0] val_rm_in;
  logic [11:0]      shift_operand_in;
  logic             imm_in;
  logic [23:0]      signed_imm_24_in;
  logic [3:0]       dest_in;
  logic [3:0]       status_in;

  logic             branch_taken;
  logic [WIDTH-1:0] branch_addr;
  logic [3:0]       status;
  logic             wb_en;
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] st_val;
  logic [3:0]       dest;

  modport master (
    output wb_en_in, mem_read_in, mem_write_in, b_in, s_in, exe_cmd_in, pc_in,
           val_rn_in, val_rm_in, shift_operand_in, imm_in, signed_imm_24_in,
           dest_in, status_in,
    input  branch_taken, branch_addr, status, wb_en, mem_read, mem_write,
           alu_res, st_val, dest
  );

  modport slave (
    input  wb_en_in, mem_read_in, mem_write_in, b_in, s_in, exe_cmd_in, pc_in,
           val_rn_in, val_rm_in, shift_operand_in, imm_in, signed_imm_24_in,
           dest_in, status_in,
    output branch_taken, branch_addr, status, wb_en, mem_read, mem_write,
           alu_res, st_val, dest
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: Val2 shifter, ALU, branch target, NZCV status register and
// the EXE/MEM pipeline register.
module exe_stage #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  exe_stage_if.slave bus
);

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } alu_cmd_e;

  function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] x, input logic [4:0] n);
    // A shift by 32 yields zero, so n = 0 leaves x intact.
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  alu_cmd_e         cmd;
  logic [WIDTH-1:0] val2;
  logic [WIDTH-1:0] rn;
  logic [32:0]      sum;
  logic [WIDTH-1:0] res;
  logic             flag_c, flag_v, cmd_ok, cin;
  logic [3:0]       status_q;
  logic             status_ld;
  logic             mem_op;
  logic             unused_status;

  assign cmd           = alu_cmd_e'(bus.exe_cmd_in);
  assign rn            = bus.val_rn_in;
  assign cin           = bus.status_in[1];
  assign mem_op        = bus.mem_read_in | bus.mem_write_in;
  assign unused_status = ^{bus.status_in[3:2], bus.status_in[0]};

  assign bus.branch_taken = bus.b_in;
  assign bus.branch_addr  = bus.pc_in + {{6{bus.signed_imm_24_in[23]}}, bus.signed_imm_24_in, 2'b00};
  assign bus.status       = status_q;

  always_comb begin
    val2 = '0;
    if (mem_op) begin
      val2 = {20'b0, bus.shift_operand_in};
    end else if (bus.imm_in) begin
      val2 = ror({24'b0, bus.shift_operand_in[7:0]}, {bus.shift_operand_in[11:8], 1'b0});
    end else begin
      case (bus.shift_operand_in[6:5])
        2'b00:   val2 = bus.val_rm_in << bus.shift_operand_in[11:7];
        2'b01:   val2 = bus.val_rm_in >> bus.shift_operand_in[11:7];
        2'b10:   val2 = WIDTH'($signed(bus.val_rm_in) >>> bus.shift_operand_in[11:7]);
        default: val2 = ror(bus.val_rm_in, bus.shift_operand_in[11:7]);
      endcase
    end
  end

  // Logical/move ops carry C and V over from the status register itself.
  always_comb begin
    sum    = '0;
    res    = '0;
    flag_c = status_q[1];
    flag_v = status_q[0];
    cmd_ok = 1'b1;
    case (cmd)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_AND: res = rn & val2;
      CMD_ORR: res = rn | val2;
      CMD_EOR: res = rn ^ val2;
      CMD_ADD, CMD_ADC: begin
        sum    = {1'b0, rn} + {1'b0, val2} + {32'b0, (cmd == CMD_ADC) & cin};
        res    = sum[31:0];
        flag_c = sum[32];
        flag_v = (rn[31] == val2[31]) && (res[31] != rn[31]);
      end
      CMD_SUB, CMD_SBC: begin
        sum    = {1'b0, rn} + {1'b0, ~val2} + {32'b0, (cmd == CMD_SUB) | cin};
        res    = sum[31:0];
        flag_c = sum[32];
        flag_v = (rn[31] != val2[31]) && (res[31] != rn[31]);
      end
      default: cmd_ok = 1'b0;
    endcase
  end

  assign status_ld = bus.s_in & ~bus.b_in & ~mem_op & cmd_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q      <= '0;
      bus.wb_en     <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.alu_res   <= '0;
      bus.st_val    <= '0;
      bus.dest      <= '0;
    end else begin
      if (status_ld) status_q <= {res[31], (res == '0), flag_c, flag_v};
      bus.wb_en     <= bus.wb_en_in;
      bus.mem_read  <= bus.mem_read_in;
      bus.mem_write <= bus.mem_write_in;
      bus.alu_res   <= res;
      bus.st_val    <= bus.val_rm_in;
      bus.dest      <= bus.dest_in;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Randomized bench for exe_stage against an arithmetic reference model,
// with a few hand-computed directed cases.
module tb_exe_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exe_stage_if #(.WIDTH(32)) bus ();
  exe_stage #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic        e_wb, e_mr, e_mw;
  logic [31:0] e_res, e_st;
  logic [3:0]  e_dest, e_status;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) x = {x[0], x[31:1]};
    return x;
  endfunction

  function automatic logic [31:0] m_val2(input logic mem, input logic imm,
                                         input logic [11:0] so, input logic [31:0] rm);
    int unsigned amt;
    if (mem) return {20'b0, so};
    if (imm) return m_rotr({24'b0, so[7:0]}, 2 * so[11:8]);
    amt = so[11:7];
    case (so[6:5])
      2'b00:   return rm << amt;
      2'b01:   return rm >> amt;
      2'b10:   return rm[31] ? ~((~rm) >> amt) : (rm >> amt);
      default: return m_rotr(rm, amt);
    endcase
  endfunction

  function automatic logic ovf(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Returns 1 when cmd is a defined ALU operation.
  function automatic logic m_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                                 input logic cin, input logic [3:0] cur,
                                 output logic [31:0] res, output logic [3:0] nzcv);
    longint unsigned ua, ub, ur;
    longint sa, sb, sr;
    logic c, v, bor;
    ua = rn; ub = v2; sa = $signed(rn); sb = $signed(v2);
    c = cur[1]; v = cur[0]; res = 0; bor = !cin;
    case (cmd)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd6: res = rn & v2;
      4'd7: res = rn | v2;
      4'd8: res = rn ^ v2;
      4'd2: begin ur = ua + ub;        res = ur[31:0]; c = ur[32];          sr = sa + sb;       v = ovf(sr); end
      4'd3: begin ur = ua + ub + cin;  res = ur[31:0]; c = ur[32];          sr = sa + sb + cin; v = ovf(sr); end
      4'd4: begin res = rn - v2;       c = (ua >= ub);                      sr = sa - sb;       v = ovf(sr); end
      4'd5: begin res = rn - v2 - bor; c = (ua >= ub + bor);                sr = sa - sb - bor; v = ovf(sr); end
      default: begin nzcv = cur; return 1'b0; end
    endcase
    nzcv = {res[31], res == 0, c, v};
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_baddr(input logic [31:0] pc, input logic [23:0] imm24);
    int off;
    off = int'(imm24);
    if (imm24[23]) off = off - 16777216;
    return pc + 32'(off * 4);
  endfunction

  task automatic model_reset();
    e_wb = 0; e_mr = 0; e_mw = 0; e_res = 0; e_st = 0; e_dest = 0; e_status = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".wb_en"},     32'(bus.wb_en),     32'(e_wb));
    chk({tag, ".mem_read"},  32'(bus.mem_read),  32'(e_mr));
    chk({tag, ".mem_write"}, 32'(bus.mem_write), 32'(e_mw));
    chk({tag, ".alu_res"},   bus.alu_res,        e_res);
    chk({tag, ".st_val"},    bus.st_val,         e_st);
    chk({tag, ".dest"},      32'(bus.dest),      32'(e_dest));
    chk({tag, ".status"},    32'(bus.status),    32'(e_status));
  endtask

  // Inputs are already applied; checks the combinational outputs, then
  // clocks one edge and checks the registered outputs against the model.
  task automatic step();
    logic [31:0] v2, res;
    logic [3:0]  nz;
    logic        ok, mem;
    #1;
    chk("branch_taken", 32'(bus.branch_taken), 32'(bus.b_in));
    chk("branch_addr", bus.branch_addr, m_baddr(bus.pc_in, bus.signed_imm_24_in));
    mem = bus.mem_read_in | bus.mem_write_in;
    v2  = m_val2(mem, bus.imm_in, bus.shift_operand_in, bus.val_rm_in);
    ok  = m_alu(bus.exe_cmd_in, bus.val_rn_in, v2, bus.status_in[1], e_status, res, nz);
    @(posedge clk);
    #1;
    e_wb = bus.wb_en_in; e_mr = bus.mem_read_in; e_mw = bus.mem_write_in;
    e_res = res; e_st = bus.val_rm_in; e_dest = bus.dest_in;
    if (ok && bus.s_in && !bus.b_in && !mem) e_status = nz;
    check_regs("cyc");
  endtask

  task automatic clr_inputs();
    bus.wb_en_in = 0; bus.mem_read_in = 0; bus.mem_write_in = 0; bus.b_in = 0;
    bus.s_in = 0; bus.exe_cmd_in = 0; bus.pc_in = 0; bus.val_rn_in = 0; bus.val_rm_in = 0;
    bus.shift_operand_in = 0; bus.imm_in = 0; bus.signed_imm_24_in = 0; bus.dest_in = 0;
    bus.status_in = 0;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] tbl [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    if ($urandom_range(0, 3) == 0) return tbl[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic rand_inputs();
    int unsigned r;
    r = $urandom_range(0, 9);
    bus.mem_read_in      = (r == 0);
    bus.mem_write_in     = (r == 1);
    bus.b_in             = ($urandom_range(0, 6) == 0);
    bus.wb_en_in         = 1'($urandom);
    bus.s_in             = 1'($urandom);
    bus.exe_cmd_in       = 4'($urandom_range(0, 15));
    bus.pc_in            = $urandom;
    bus.val_rn_in        = pick();
    bus.val_rm_in        = pick();
    bus.shift_operand_in = 12'($urandom);
    bus.imm_in           = 1'($urandom);
    bus.signed_imm_24_in = 24'($urandom);
    bus.dest_in          = 4'($urandom);
    bus.status_in        = 4'($urandom);
  endtask

  initial begin
    clr_inputs();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    rst = 1'b0;

    clr_inputs(); bus.exe_cmd_in = 4'b0010; bus.imm_in = 1; bus.shift_operand_in = 12'h0FF;
    bus.val_rn_in = 5; bus.s_in = 1; bus.wb_en_in = 1; bus.dest_in = 4'd3;
    step();
    chk("add_imm.res", bus.alu_res, 32'd260);
    chk("add_imm.status", 32'(bus.status), 32'h0);

    clr_inputs(); bus.exe_cmd_in = 4'b0001; bus.imm_in = 1; bus.shift_operand_in = 12'h4FF;
    step();
    chk("mov_rot.res", bus.alu_res, 32'hFF000000);

    clr_inputs(); bus.exe_cmd_in = 4'b0001; bus.val_rm_in = 32'h80000000;
    bus.shift_operand_in = {5'd4, 2'b10, 5'd0};
    step();
    chk("asr.res", bus.alu_res, 32'hF8000000);

    clr_inputs(); bus.exe_cmd_in = 4'b0100; bus.s_in = 1; bus.val_rn_in = 3;
    bus.imm_in = 1; bus.shift_operand_in = 12'h003;
    step();
    chk("sub_zero.res", bus.alu_res, 32'h0);
    chk("sub_zero.status", 32'(bus.status), 32'h6);

    clr_inputs(); bus.exe_cmd_in = 4'b0010; bus.s_in = 1; bus.val_rn_in = 32'h7FFFFFFF;
    bus.imm_in = 1; bus.shift_operand_in = 12'h001;
    step();
    chk("add_ovf.res", bus.alu_res, 32'h80000000);
    chk("add_ovf.status", 32'(bus.status), 32'h9);

    clr_inputs(); bus.exe_cmd_in = 4'b0010; bus.mem_read_in = 1; bus.s_in = 1;
    bus.val_rn_in = 32'h100; bus.imm_in = 1; bus.shift_operand_in = 12'h804;
    step();
    chk("ldr.res", bus.alu_res, 32'h904);
    chk("ldr.mem_read", 32'(bus.mem_read), 32'h1);
    chk("ldr.status", 32'(bus.status), 32'h9);

    clr_inputs(); bus.b_in = 1; bus.pc_in = 32'h100; bus.signed_imm_24_in = 24'hFFFFFE;
    bus.s_in = 1; bus.exe_cmd_in = 4'b0100;
    #1;
    chk("br.taken", 32'(bus.branch_taken), 32'h1);
    chk("br.addr", bus.branch_addr, 32'hF8);
    step();
    chk("br.status", 32'(bus.status), 32'h9);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_regs("rst_async");
        rand_inputs();
        @(posedge clk);
        #1;
        check_regs("rst_held");
        rst = 1'b0;
        #2;
        check_regs("rst_released");
      end
      rand_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete at %0t", $time);
    $fatal(1);
  end
endmodule
